// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: drains an async FIFO read port into a valid/ready stream with 2-entry skid buffer, packet framing and sticky underflow capture.
module fifo_read_streamer #(
  parameter int FIFO_WIDTH = 16,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  err_underflow
);
  localparam int BW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  logic [FIFO_WIDTH-1:0] buf_q [2];
  logic [1:0] occ;
  logic inflight, head, tail, pop, cap;
  logic [BW-1:0] beat_cnt;
  logic [2:0] credit;
  assign pop = m_valid & m_ready;
  assign cap = inflight & ~fifo_underflow;
  // Words already requested count against the buffer so it can never overflow.
  assign credit = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign fifo_rd_en = ~rst_n & ~fifo_empty & (credit < 3'd2);
  assign m_valid = occ != 2'd0;
  assign m_data = m_valid ? buf_q[head] : '0;
  assign m_last = m_valid & (beat_cnt == BW'(PKT_LEN - 1));
  always_ff @(posedge clk) begin
    if (rst_n) begin
      occ <= '0;
      inflight <= 1'b0;
      head <= 1'b0;
      tail <= 1'b0;
      beat_cnt <= '0;
      pkt_count <= '0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      occ <= occ + {1'b0, cap} - {1'b0, pop};
      if (cap) begin
        buf_q[tail] <= fifo_data_out;
        tail <= ~tail;
      end
      if (pop) begin
        head <= ~head;
        beat_cnt <= m_last ? '0 : beat_cnt + BW'(1);
      end
      if (pop & m_last) pkt_count <= pkt_count + CNT_WIDTH'(1);
      if (inflight & fifo_underflow) err_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_read_streamer.sv
// tb_fifo_read_streamer: FIFO responder model plus word-order/framing scoreboard around fifo_read_streamer.
module tb_fifo_read_streamer;
  localparam int W = 16;
  localparam int PL = 4;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [W-1:0] fifo_data_out = '0;
  logic fifo_underflow = 1'b0;
  logic fifo_empty, fifo_rd_en, m_valid, m_last, err_underflow;
  logic m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic [CW-1:0] pkt_count;
  always #5 clk = ~clk;
  fifo_read_streamer #(.FIFO_WIDTH(W), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .pkt_count(pkt_count),
    .err_underflow(err_underflow));
  logic [W-1:0] fmem [0:4095];
  logic [W-1:0] emem [0:4095];
  logic [11:0] wr_p = '0, rd_p = '0, e_wr = '0, e_rd = '0;
  logic uf_en = 1'b0;
  logic [W-1:0] uf_word = '0;
  assign fifo_empty = (wr_p == rd_p);
  // FIFO with one-cycle read latency; every word it hands out is expected downstream unless flagged as underflow.
  always @(posedge clk) begin
    fifo_underflow <= 1'b0;
    if (fifo_rd_en) begin
      fifo_data_out <= fmem[rd_p];
      rd_p <= rd_p + 12'd1;
      if (uf_en && fmem[rd_p] == uf_word) fifo_underflow <= 1'b1;
      else begin
        emem[e_wr] <= fmem[rd_p];
        e_wr <= e_wr + 12'd1;
      end
    end
  end
  int n_chk = 0, n_fail = 0, beats = 0;
  logic last_rst = 1'b0, exp_err = 1'b0, stall_prev = 1'b0;
  logic [W-1:0] stall_data = '0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (last_rst) begin
      chk("rst_flags", 32'({m_valid, m_last, err_underflow}), 32'(0));
      chk("rst_data", 32'(m_data), 32'(0));
      chk("rst_pkt", 32'(pkt_count), 32'(0));
    end
    if (rst_n) begin
      chk("rst_rd_en", 32'(fifo_rd_en), 32'(0));
      e_rd = e_wr;
      beats = 0;
      exp_err = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (fifo_rd_en) chk("rd_when_empty", 32'(fifo_empty), 32'(0));
      if (stall_prev) begin
        chk("hold_valid", 32'(m_valid), 32'(1));
        chk("hold_data", 32'(m_data), 32'(stall_data));
      end
      chk("m_last", 32'(m_last), 32'(m_valid && (beats % PL == PL - 1)));
      chk("err_underflow", 32'(err_underflow), 32'(exp_err));
      if (m_valid && m_ready) begin
        if (e_rd == e_wr) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_word: got %0h expected none", m_data);
        end else begin
          chk("order", 32'(m_data), 32'(emem[e_rd]));
          e_rd = e_rd + 12'd1;
        end
        chk("pkt_count", 32'(pkt_count), 32'(CW'(beats / PL)));
        beats++;
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
      if (fifo_underflow) exp_err = 1'b1;
    end
    @(posedge clk);
    last_rst = rst_n;
    #1;
  endtask
  task automatic push(input logic [W-1:0] w);
    fmem[wr_p] = w;
    wr_p = wr_p + 12'd1;
  endtask
  task automatic do_reset();
    rst_n = 1'b1;
    step();
    step();
  endtask
  task automatic wait_beats(input int n, input int lim);
    int k;
    k = 0;
    while (beats < n && k < lim) begin
      step();
      k++;
    end
    chk("beats_reached", 32'(beats), 32'(n));
  endtask
  typedef struct {
    int nwords;
    int stall;
    int exp_pkts;
  } vec_t;
  vec_t vecs [6];
  initial begin
    int rd, v, total;
    vecs[0] = '{5, 0, 1};
    vecs[1] = '{8, 3, 2};
    vecs[2] = '{3, 6, 0};
    vecs[3] = '{12, 2, 3};
    vecs[4] = '{1, 1, 0};
    vecs[5] = '{9, 10, 2};
    // Reset with a non-empty FIFO, then latency and full-rate streaming.
    for (int i = 1; i <= 8; i++) push(W'(i));
    m_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("first_rd_en", 32'(fifo_rd_en), 32'(1));
    chk("c1_valid", 32'(m_valid), 32'(0));
    step();
    chk("c2_valid", 32'(m_valid), 32'(0));
    step();
    chk("c3_valid", 32'(m_valid), 32'(1));
    chk("stream_data", 32'(m_data), 32'(1));
    for (int i = 1; i < 8; i++) begin
      step();
      chk("stream_valid", 32'(m_valid), 32'(1));
      chk("stream_data", 32'(m_data), 32'(i + 1));
      chk("stream_last", 32'(m_last), 32'(i % 4 == 3));
    end
    step();
    chk("stream_pkts", 32'(pkt_count), 32'(2));
    chk("stream_done", 32'(m_valid), 32'(0));
    // Back-pressure saturates the buffer at two words.
    do_reset();
    for (int i = 1; i <= 6; i++) push(W'(i));
    m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    rd = int'(fifo_rd_en);
    repeat (5) begin
      step();
      rd += int'(fifo_rd_en);
    end
    chk("bp_issues", 32'(rd), 32'(2));
    chk("bp_valid", 32'(m_valid), 32'(1));
    chk("bp_data", 32'(m_data), 32'(1));
    m_ready = 1'b1;
    wait_beats(6, 30);
    step();
    chk("bp_pkts", 32'(pkt_count), 32'(1));
    chk("bp_drained", 32'(fifo_empty), 32'(1));
    // Single word: one read, one beat.
    do_reset();
    push(16'h00aa);
    rst_n = 1'b0;
    #1;
    rd = int'(fifo_rd_en);
    v = 0;
    repeat (7) begin
      step();
      rd += int'(fifo_rd_en);
      v += int'(m_valid);
    end
    chk("empty_issues", 32'(rd), 32'(1));
    chk("empty_beats", 32'(v), 32'(1));
    // Underflow on word 3 drops it and latches the error until reset.
    do_reset();
    for (int i = 1; i <= 6; i++) push(W'(i));
    uf_word = 16'h0003;
    uf_en = 1'b1;
    rst_n = 1'b0;
    wait_beats(5, 30);
    repeat (3) step();
    chk("uf_beats", 32'(beats), 32'(5));
    chk("uf_sticky", 32'(err_underflow), 32'(1));
    do_reset();
    chk("uf_cleared", 32'(err_underflow), 32'(0));
    uf_en = 1'b0;
    // Reset mid-packet with the buffer full.
    for (int i = 1; i <= 10; i++) push(W'(16'h0100 + i));
    rst_n = 1'b0;
    wait_beats(2, 20);
    m_ready = 1'b0;
    repeat (4) step();
    chk("mid_full_valid", 32'(m_valid), 32'(1));
    chk("mid_full_block", 32'(fifo_rd_en), 32'(0));
    do_reset();
    chk("mid_cleared", 32'(m_valid), 32'(0));
    rst_n = 1'b0;
    m_ready = 1'b1;
    wait_beats(4, 20);
    chk("mid_pkt", 32'(pkt_count), 32'(1));
    repeat (10) step();
    // Table: word count and initial stall against expected packets.
    foreach (vecs[j]) begin
      do_reset();
      for (int i = 0; i < vecs[j].nwords; i++) push(W'(16'h0200 + i));
      m_ready = 1'b0;
      rst_n = 1'b0;
      repeat (vecs[j].stall) step();
      m_ready = 1'b1;
      wait_beats(vecs[j].nwords, 60);
      repeat (2) step();
      chk("tbl_pkts", 32'(pkt_count), 32'(vecs[j].exp_pkts));
      chk("tbl_idle", 32'(m_valid), 32'(0));
    end
    // Random traffic and random back-pressure.
    do_reset();
    rst_n = 1'b0;
    total = 0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom % 3 != 0) begin
        push(W'($urandom));
        total++;
      end
      m_ready = ($urandom % 4) != 0;
      step();
    end
    m_ready = 1'b1;
    wait_beats(total, 3000);
    step();
    chk("rand_pkts", 32'(pkt_count), 32'(CW'(total / PL)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
